// File: rtl/eth_tx_arb_pkg.sv
// Shared widths and FSM state type for the Ethernet TX header/payload arbiter.
package eth_tx_arb_pkg;

  localparam int MAC_W  = 48;
  localparam int TYPE_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]         o_grant_oh,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   v_sum;
  logic [IDX_W-1:0] v_idx;

  // One spare bit holds ptr+k before the modulo-NUM_REQ fold.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    v_sum       = '0;
    v_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (v_sum >= (IDX_W+1)'(NUM_REQ)) begin
        v_sum = v_sum - (IDX_W+1)'(NUM_REQ);
      end
      v_idx = v_sum[IDX_W-1:0];
      if (!o_any && i_req[v_idx]) begin
        o_any              = 1'b1;
        o_grant_idx        = v_idx;
        o_grant_oh[v_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_hdr_arbiter.sv
// Round-robin arbiter sharing one Ethernet TX header+payload channel among NUM_REQ requesters.
//   state      | meaning
//   ST_IDLE    | no owner; arbitrate when TX core not busy
//   ST_HDR     | owner's header presented, waiting for header handshake
//   ST_PAYLOAD | owner's payload forwarded until the tlast beat is accepted
module eth_tx_hdr_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_hdr_valid,
  output logic [NUM_REQ-1:0]           req_hdr_ready,
  input  logic [MAC_W*NUM_REQ-1:0]     req_dest_mac,
  input  logic [MAC_W*NUM_REQ-1:0]     req_src_mac,
  input  logic [TYPE_W*NUM_REQ-1:0]    req_eth_type,
  input  logic [DATA_W*NUM_REQ-1:0]    req_tdata,
  input  logic [NUM_REQ-1:0]           req_tvalid,
  input  logic [NUM_REQ-1:0]           req_tlast,
  input  logic [NUM_REQ-1:0]           req_tuser,
  output logic [NUM_REQ-1:0]           req_tready,
  output logic                         s_eth_hdr_valid,
  output logic [MAC_W-1:0]             s_eth_dest_mac,
  output logic [MAC_W-1:0]             s_eth_src_mac,
  output logic [TYPE_W-1:0]            s_eth_type,
  input  logic                         s_eth_hdr_ready,
  output logic [DATA_W-1:0]            s_eth_payload_axis_tdata,
  output logic                         s_eth_payload_axis_tvalid,
  output logic                         s_eth_payload_axis_tlast,
  output logic                         s_eth_payload_axis_tuser,
  input  logic                         s_eth_payload_axis_tready,
  input  logic                         busy,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_rr_ptr;

  logic [IDX_W-1:0]   w_arb_idx;
  logic [NUM_REQ-1:0] w_arb_oh;
  logic               w_arb_any;
  logic               w_start;
  logic               w_done;

  logic [MAC_W-1:0]  w_dest [NUM_REQ];
  logic [MAC_W-1:0]  w_src  [NUM_REQ];
  logic [TYPE_W-1:0] w_type [NUM_REQ];
  logic [DATA_W-1:0] w_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_dest[g] = req_dest_mac[g*MAC_W +: MAC_W];
    assign w_src[g]  = req_src_mac[g*MAC_W +: MAC_W];
    assign w_type[g] = req_eth_type[g*TYPE_W +: TYPE_W];
    assign w_data[g] = req_tdata[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req       (req_hdr_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_oh  (w_arb_oh),
    .o_grant_idx (w_arb_idx),
    .o_any       (w_arb_any)
  );

  always_comb begin
    w_state_nxt               = r_state;
    w_start                   = 1'b0;
    w_done                    = 1'b0;
    req_hdr_ready             = '0;
    req_tready                = '0;
    s_eth_hdr_valid           = 1'b0;
    s_eth_dest_mac            = '0;
    s_eth_src_mac             = '0;
    s_eth_type                = '0;
    s_eth_payload_axis_tdata  = '0;
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    s_eth_payload_axis_tuser  = 1'b0;
    grant_valid               = r_grant_valid;
    grant_idx                 = r_grant_idx;

    unique case (r_state)
      ST_IDLE: begin
        if (!busy && w_arb_any) begin
          w_start     = 1'b1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        s_eth_hdr_valid            = req_hdr_valid[r_grant_idx];
        s_eth_dest_mac             = w_dest[r_grant_idx];
        s_eth_src_mac              = w_src[r_grant_idx];
        s_eth_type                 = w_type[r_grant_idx];
        req_hdr_ready[r_grant_idx] = s_eth_hdr_ready;
        if (s_eth_hdr_valid && s_eth_hdr_ready) begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        s_eth_payload_axis_tvalid = req_tvalid[r_grant_idx];
        s_eth_payload_axis_tdata  = w_data[r_grant_idx];
        s_eth_payload_axis_tlast  = req_tlast[r_grant_idx];
        s_eth_payload_axis_tuser  = req_tuser[r_grant_idx];
        req_tready[r_grant_idx]   = s_eth_payload_axis_tready;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready && s_eth_payload_axis_tlast) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Reset silences every handshake output in the very cycle it is asserted.
    if (rst) begin
      w_state_nxt               = ST_IDLE;
      w_start                   = 1'b0;
      w_done                    = 1'b0;
      req_hdr_ready             = '0;
      req_tready                = '0;
      s_eth_hdr_valid           = 1'b0;
      s_eth_dest_mac            = '0;
      s_eth_src_mac             = '0;
      s_eth_type                = '0;
      s_eth_payload_axis_tdata  = '0;
      s_eth_payload_axis_tvalid = 1'b0;
      s_eth_payload_axis_tlast  = 1'b0;
      s_eth_payload_axis_tuser  = 1'b0;
      grant_valid               = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_grant_idx   <= w_arb_idx;
        r_grant_valid <= 1'b1;
      end
      if (w_done) begin
        r_grant_valid <= 1'b0;
        r_rr_ptr      <= (r_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_hdr_arbiter.sv
// Directed bench for eth_tx_hdr_arbiter with a cycle-level ownership model checked every cycle.
module tb_eth_tx_hdr_arbiter;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_hdr_valid = '0;
  logic [N-1:0]     req_hdr_ready;
  logic [48*N-1:0]  req_dest_mac = '0;
  logic [48*N-1:0]  req_src_mac = '0;
  logic [16*N-1:0]  req_eth_type = '0;
  logic [8*N-1:0]   req_tdata = '0;
  logic [N-1:0]     req_tvalid = '0;
  logic [N-1:0]     req_tlast = '0;
  logic [N-1:0]     req_tuser = '0;
  logic [N-1:0]     req_tready;
  logic             s_eth_hdr_valid;
  logic [47:0]      s_eth_dest_mac;
  logic [47:0]      s_eth_src_mac;
  logic [15:0]      s_eth_type;
  logic             s_eth_hdr_ready = 1'b1;
  logic [7:0]       s_eth_payload_axis_tdata;
  logic             s_eth_payload_axis_tvalid;
  logic             s_eth_payload_axis_tlast;
  logic             s_eth_payload_axis_tuser;
  logic             s_eth_payload_axis_tready = 1'b1;
  logic             busy = 1'b0;
  logic             grant_valid;
  logic [0:0]       grant_idx;

  eth_tx_hdr_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_hdr_valid(req_hdr_valid), .req_hdr_ready(req_hdr_ready),
    .req_dest_mac(req_dest_mac), .req_src_mac(req_src_mac), .req_eth_type(req_eth_type),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast), .req_tuser(req_tuser),
    .req_tready(req_tready),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac),
    .s_eth_type(s_eth_type), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata), .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast), .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .busy(busy), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side packet sources: phase 0 none, 1 header pending, 2 payload.
  logic [7:0]  pk_data [N][8];
  logic [47:0] pk_dst [N];
  logic [15:0] pk_type [N];
  bit          pk_user [N];
  int          pk_len [N];
  int          pk_pos [N];
  int          src_ph [N];
  bit          hdr_mask [N];

  // Reference model: who owns the channel and how far its packet has got.
  int m_owner = -1;
  int m_phase = 0;
  int m_ptr   = 0;
  int m_gidx  = 0;

  int          grants_q [$];
  logic [11:0] beats_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s actual=expired expected=completion at %0t", nm, $time);
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_hdr_valid[i]        = (src_ph[i] == 1) && !hdr_mask[i];
      req_dest_mac[i*48 +: 48] = pk_dst[i];
      req_src_mac[i*48 +: 48]  = pk_dst[i] ^ 48'hFFFF_0000_0000;
      req_eth_type[i*16 +: 16] = pk_type[i];
      req_tvalid[i]           = (src_ph[i] == 2);
      req_tdata[i*8 +: 8]     = pk_data[i][pk_pos[i]];
      req_tlast[i]            = (pk_pos[i] == pk_len[i] - 1);
      req_tuser[i]            = pk_user[i] && (pk_pos[i] == pk_len[i] - 1);
    end
  endtask

  task automatic load(input int i, input logic [47:0] dst, input logic [15:0] ty,
                      input int len, input logic [7:0] base, input bit user);
    pk_dst[i]  = dst;
    pk_type[i] = ty;
    pk_len[i]  = len;
    pk_user[i] = user;
    pk_pos[i]  = 0;
    src_ph[i]  = 1;
    for (int k = 0; k < 8; k++) pk_data[i][k] = base + 8'(k);
    drive_src();
  endtask

  // One clock: check outputs against the model at negedge, advance model at posedge.
  task automatic step();
    int o;
    int w;
    int n_owner, n_phase, n_ptr, n_gidx;
    logic [N-1:0] hh, dh, exp_hr, exp_tr;
    logic exp_gv, exp_hv, exp_tv;
    @(negedge clk);
    o = (m_owner < 0) ? 0 : m_owner;
    exp_gv = !rst && (m_phase != 0);
    exp_hv = !rst && (m_phase == 1) && req_hdr_valid[o];
    exp_tv = !rst && (m_phase == 2) && req_tvalid[o];
    exp_hr = '0;
    exp_tr = '0;
    if (!rst && m_phase == 1) exp_hr[o] = s_eth_hdr_ready;
    if (!rst && m_phase == 2) exp_tr[o] = s_eth_payload_axis_tready;
    chk("grant_valid", 64'(grant_valid), 64'(exp_gv));
    chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
    chk("hdr_valid", 64'(s_eth_hdr_valid), 64'(exp_hv));
    chk("req_hdr_ready", 64'(req_hdr_ready), 64'(exp_hr));
    chk("tvalid", 64'(s_eth_payload_axis_tvalid), 64'(exp_tv));
    chk("req_tready", 64'(req_tready), 64'(exp_tr));
    if (exp_hv) begin
      chk("dest_mac", 64'(s_eth_dest_mac), 64'(pk_dst[o]));
      chk("src_mac", 64'(s_eth_src_mac), 64'(pk_dst[o] ^ 48'hFFFF_0000_0000));
      chk("eth_type", 64'(s_eth_type), 64'(pk_type[o]));
    end
    if (exp_tv) begin
      chk("tdata", 64'(s_eth_payload_axis_tdata), 64'(pk_data[o][pk_pos[o]]));
      chk("tlast", 64'(s_eth_payload_axis_tlast), 64'(pk_pos[o] == pk_len[o] - 1));
      chk("tuser", 64'(s_eth_payload_axis_tuser), 64'(pk_user[o] && (pk_pos[o] == pk_len[o] - 1)));
    end
    if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready)
      beats_q.push_back({4'(o), s_eth_payload_axis_tdata});
    for (int i = 0; i < N; i++) begin
      hh[i] = req_hdr_valid[i] && req_hdr_ready[i];
      dh[i] = req_tvalid[i] && req_tready[i];
    end
    n_owner = m_owner; n_phase = m_phase; n_ptr = m_ptr; n_gidx = m_gidx;
    if (rst) begin
      n_owner = -1; n_phase = 0; n_ptr = 0; n_gidx = 0;
    end else if (m_phase == 0) begin
      if (!busy && (req_hdr_valid != '0)) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_hdr_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        n_owner = w; n_gidx = w; n_phase = 1;
        grants_q.push_back(w);
      end
    end else if (m_phase == 1) begin
      if (req_hdr_valid[o] && s_eth_hdr_ready) n_phase = 2;
    end else begin
      if (req_tvalid[o] && s_eth_payload_axis_tready && req_tlast[o]) begin
        n_phase = 0; n_owner = -1; n_ptr = (o + 1) % N;
      end
    end
    @(posedge clk);
    m_owner = n_owner; m_phase = n_phase; m_ptr = n_ptr; m_gidx = n_gidx;
    #1;
    for (int i = 0; i < N; i++) begin
      if (hh[i]) begin
        src_ph[i] = 2;
        pk_pos[i] = 0;
      end else if (dh[i]) begin
        if (pk_pos[i] == pk_len[i] - 1) src_ph[i] = 0;
        else pk_pos[i]++;
      end
    end
    drive_src();
  endtask

  task automatic run_idle(input int max, input bit toggle);
    int n;
    n = 0;
    while ((src_ph[0] != 0 || src_ph[1] != 0 || m_phase != 0) && n < max) begin
      if (toggle) s_eth_payload_axis_tready = ~s_eth_payload_axis_tready;
      step();
      n++;
    end
    if (n >= max) timeout("run_idle");
    s_eth_payload_axis_tready = 1'b1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_ph[i] = 0; pk_pos[i] = 0; pk_len[i] = 1; hdr_mask[i] = 0;
      pk_dst[i] = '0; pk_type[i] = '0; pk_user[i] = 0;
      for (int k = 0; k < 8; k++) pk_data[i][k] = '0;
    end
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    step();
    step();
    rst = 1'b0;
    grants_q.delete();
    beats_q.delete();
  endtask

  initial begin
    int n;
    int cnt0;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset grant_valid", 64'(grant_valid), 64'd0);
    chk("reset grant_idx", 64'(grant_idx), 64'd0);
    chk("reset hdr_valid", 64'(s_eth_hdr_valid), 64'd0);

    // Single request, 3-beat payload.
    load(0, 48'h1122_3344_5566, 16'h0800, 3, 8'hA1, 1'b1);
    step();
    chk("t1 hdr_valid latency", 64'(s_eth_hdr_valid), 64'd1);
    chk("t1 dest", 64'(s_eth_dest_mac), 64'h1122_3344_5566);
    chk("t1 type", 64'(s_eth_type), 64'h0800);
    run_idle(40, 1'b0);
    chk("t1 beat count", 64'(beats_q.size()), 64'd3);
    if (beats_q.size() == 3) begin
      chk("t1 beat0", 64'(beats_q[0]), 64'h0A1);
      chk("t1 beat1", 64'(beats_q[1]), 64'h0A2);
      chk("t1 beat2", 64'(beats_q[2]), 64'h0A3);
    end
    chk("t1 idle grant_valid", 64'(grant_valid), 64'd0);

    // Simultaneous requests: req0 then req1, pointer wraps back to 0.
    do_reset();
    load(0, 48'hA0A0_A0A0_A0A0, 16'h86DD, 2, 8'h10, 1'b0);
    load(1, 48'hB1B1_B1B1_B1B1, 16'h0806, 2, 8'h20, 1'b1);
    run_idle(60, 1'b0);
    chk("t2 grants", 64'(grants_q.size()), 64'd2);
    if (grants_q.size() == 2) begin
      chk("t2 first", 64'(grants_q[0]), 64'd0);
      chk("t2 second", 64'(grants_q[1]), 64'd1);
    end
    if (beats_q.size() == 4) chk("t2 req1 beat0", 64'(beats_q[2]), 64'h120);
    else chk("t2 beat count", 64'(beats_q.size()), 64'd4);
    load(0, 48'hA0A0_A0A0_A0A1, 16'h86DD, 1, 8'h11, 1'b0);
    load(1, 48'hB1B1_B1B1_B1B2, 16'h0806, 1, 8'h21, 1'b0);
    run_idle(60, 1'b0);
    if (grants_q.size() == 4) chk("t2 ptr wrapped to 0", 64'(grants_q[2]), 64'd0);
    else chk("t2 grants round2", 64'(grants_q.size()), 64'd4);

    // Busy holds off arbitration.
    busy = 1'b1;
    load(1, 48'hC2C2_C2C2_C2C2, 16'h0800, 2, 8'h30, 1'b0);
    repeat (5) step();
    chk("t3 busy no grant", 64'(grant_valid), 64'd0);
    chk("t3 busy no hdr", 64'(s_eth_hdr_valid), 64'd0);
    busy = 1'b0;
    step();
    chk("t3 grant after busy", 64'(grant_valid), 64'd1);
    chk("t3 grant idx", 64'(grant_idx), 64'd1);
    run_idle(40, 1'b0);

    // Header back-pressure.
    s_eth_hdr_ready = 1'b0;
    load(0, 48'hDEAD_BEEF_0001, 16'h88F7, 2, 8'h40, 1'b0);
    step();
    repeat (4) step();
    chk("t4 hdr held", 64'(s_eth_hdr_valid), 64'd1);
    chk("t4 hdr_ready low", 64'(req_hdr_ready), 64'd0);
    chk("t4 no payload", 64'(s_eth_payload_axis_tvalid), 64'd0);
    chk("t4 dest stable", 64'(s_eth_dest_mac), 64'hDEAD_BEEF_0001);
    s_eth_hdr_ready = 1'b1;
    run_idle(40, 1'b0);

    // Granted requester drops hdr_valid in HDR: no re-arbitration.
    grants_q.delete();
    s_eth_hdr_ready = 1'b0;
    load(1, 48'h0101_0101_0101, 16'h0800, 1, 8'h50, 1'b0);
    step();
    chk("t5 granted 1", 64'(grant_idx), 64'd1);
    hdr_mask[1] = 1'b1;
    load(0, 48'h0202_0202_0202, 16'h0800, 1, 8'h58, 1'b0);
    repeat (3) step();
    chk("t5 grant kept", 64'(grant_idx), 64'd1);
    chk("t5 grant_valid kept", 64'(grant_valid), 64'd1);
    chk("t5 hdr_valid follows req", 64'(s_eth_hdr_valid), 64'd0);
    hdr_mask[1] = 1'b0;
    s_eth_hdr_ready = 1'b1;
    drive_src();
    run_idle(60, 1'b0);
    if (grants_q.size() == 2) chk("t5 then req0", 64'(grants_q[1]), 64'd0);
    else chk("t5 grants", 64'(grants_q.size()), 64'd2);

    // Reset during beat 2 of a req1 packet.
    do_reset();
    load(1, 48'h0303_0303_0303, 16'h0800, 4, 8'h60, 1'b0);
    n = 0;
    while (!(src_ph[1] == 2 && pk_pos[1] == 1) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) timeout("t6 beat2");
    chk("t6 beat2 live", 64'(s_eth_payload_axis_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6 rst tvalid", 64'(s_eth_payload_axis_tvalid), 64'd0);
    chk("t6 rst tready", 64'(req_tready), 64'd0);
    chk("t6 rst grant_valid", 64'(grant_valid), 64'd0);
    chk("t6 rst hdr_ready", 64'(req_hdr_ready), 64'd0);
    step();
    rst = 1'b0;
    clear_src();
    grants_q.delete();
    beats_q.delete();
    load(0, 48'h0404_0404_0404, 16'h0800, 1, 8'h68, 1'b0);
    load(1, 48'h0505_0505_0505, 16'h0800, 1, 8'h6C, 1'b0);
    run_idle(60, 1'b0);
    if (grants_q.size() == 2) begin
      chk("t6 post-reset first", 64'(grants_q[0]), 64'd0);
      chk("t6 post-reset second", 64'(grants_q[1]), 64'd1);
    end else chk("t6 grants", 64'(grants_q.size()), 64'd2);

    // Single-beat packet with toggling tready while req1 waits.
    grants_q.delete();
    beats_q.delete();
    s_eth_payload_axis_tready = 1'b0;
    load(0, 48'h0606_0606_0606, 16'h0800, 1, 8'h77, 1'b1);
    load(1, 48'h0707_0707_0707, 16'h0800, 2, 8'h7A, 1'b0);
    n = 0;
    while (src_ph[0] != 0 && n < 30) begin
      s_eth_payload_axis_tready = ~s_eth_payload_axis_tready;
      step();
      n++;
    end
    if (n >= 30) timeout("t7 single beat");
    cnt0 = 0;
    foreach (beats_q[j]) if (beats_q[j][11:8] == 4'd0) cnt0++;
    chk("t7 one beat", 64'(cnt0), 64'd1);
    if (beats_q.size() > 0) chk("t7 beat data", 64'(beats_q[0]), 64'h077);
    run_idle(60, 1'b1);
    if (grants_q.size() == 2) chk("t7 then req1", 64'(grants_q[1]), 64'd1);
    else chk("t7 grants", 64'(grants_q.size()), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
